dbus_uart_tx: RTL
=================

// Module: dbus_uart_tx
// PURPOSE
//  Memory-mapped UART transmitter; the responder side of the core's data bus (req/we/waddr/wdata/raddr/rdata).
//  Decodes a 16-byte window at BASE_ADDR, buffers written bytes in a FIFO, serialises them 8N1 on tx_o.
//  Sits beside data_mem on the mem_ctrl outputs; the top-level mux selects mem_rdata_o when the address hits.
// PARAMETERS
//  BASE_ADDR    32'h1000_0000  window base; bits [3:0] ignored
//  FIFO_DEPTH   8              TX FIFO entries; power of two, >=2
//  DEFAULT_DIV  16'd868        reset value of BAUD_DIV, in clk cycles per bit
// PORTS
//  clk          in   1   clock
//  rst          in   1   synchronous reset, active-high
//  mem_req_i    in   1   bus access request
//  mem_we_i     in   1   1 = write, 0 = read
//  mem_waddr_i  in   32  write byte address
//  mem_wdata_i  in   32  write data
//  mem_raddr_i  in   32  read byte address
//  mem_rdata_o  out  32  read data (combinational); 0 when not hit
//  tx_o         out  1   serial line (registered), idle high
//  tx_idle_o    out  1   FIFO empty and serialiser idle (registered)
// BEHAVIOUR
//  Clock is clk. Reset is synchronous and active-high on rst; polarity and synchronicity are fixed.
//  Decode: hit = addr[31:4]==BASE_ADDR[31:4]; register = addr[3:2]; byte address bits [1:0] ignored.
//  Regs: 0x0 TXDATA (W: push wdata[7:0]; R: 0)
//        0x4 STATUS (R: b0 full, b1 empty, b2 busy, b3 ovf, b[15:8] count; W: 1 to b3 clears ovf)
//        0x8 BAUD_DIV (RW [15:0]; a write of 0 stores 1)
//        0xC reserved (R: 0, W: ignored).
//  Write: takes effect at the clk edge where mem_req_i & mem_we_i & hit. Read: mem_rdata_o valid in the same cycle.
//  Reset values: tx_o=1, tx_idle_o=1, FIFO empty, ovf=0, BAUD_DIV=DEFAULT_DIV, FSM=IDLE.
//    mem_rdata_o is 0 unless a read hits.
//  FIFO: full and empty use pre-edge state.
//    A push while full is dropped and sets ovf (sticky), even if a pop occurs on the same edge.
//    Pointers wrap modulo FIFO_DEPTH. The count field reports 0..FIFO_DEPTH.
//  FSM: IDLE -> START -> DATA (8 bits, LSB first) -> STOP -> IDLE or START.
//    IDLE: if FIFO not empty, pop at the next edge, latch byte and BAUD_DIV, drive tx_o=0, enter START.
//    Each bit lasts exactly the latched div cycles. A counter counts div-1..0; at 0 advance.
//    Bit index 0..7 in DATA.
//    STOP: tx_o=1 for div cycles. At the end, if FIFO not empty, pop and go straight to START (no idle gap).
//    Otherwise go to IDLE.
//  Latency: TXDATA write at edge E into empty FIFO with FSM IDLE -> tx_o low after edge E+1.
//  BAUD_DIV writes mid-frame affect only the next frame (divisor latched at pop).
//  busy = FSM != IDLE. tx_idle_o = empty & ~busy, registered.
//  Reset mid-frame: tx_o=1 after the reset edge, the frame is aborted, FIFO contents are discarded.
//  Simultaneous TXDATA write and pop on a non-full FIFO: both occur, count unchanged.
// CONFIGURATION
//  UART_TX_PARITY_EN defined:
//    PARITY state between DATA and STOP sends the even-parity bit (XOR of the 8 data bits) for div cycles.
//    Frame = 11 bits.
//  Undefined: no PARITY state; 8N1 frame = 10 bits; RTL otherwise identical.
// TESTING
//  T1 reset: assert rst 2 cycles -> tx_o=1, tx_idle_o=1, STATUS reads 0x0000_0002, BAUD_DIV reads DEFAULT_DIV.
//  T2 single frame: BAUD_DIV=4, write 0x55 to TXDATA -> tx_o low 1 edge later.
//    Expect 4 cycles each of 0,1,0,1,0,1,0,1,0, then 1 (stop); 40 cycles total; then tx_idle_o=1.
//    With UART_TX_PARITY_EN the parity bit is 0; 44 cycles.
//  T3 overflow: BAUD_DIV=2, 10 back-to-back TXDATA writes 0x00..0x09 -> 9 frames 0x00..0x08 sent.
//    Expect STATUS.ovf=1; writing 0x8 to STATUS clears ovf.
//  T4 back-to-back frames: two writes 0xA5, 0x3C -> second start bit begins the cycle after the first stop bit.
//    Expect no idle gap.
//  T5 decode: write to BASE_ADDR+0x10 and reads of 0xC / TXDATA -> no push; mem_rdata_o=0.
//    BAUD_DIV write 0 reads back 1.
//  T6 reset mid-frame: rst during DATA bit 3 -> tx_o=1 next edge, FIFO empty, a new write restarts a clean frame.

Source files
------------

// File: rtl/dbus_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the core data bus: TXDATA/STATUS/BAUD_DIV window, TX FIFO, serialiser.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module dbus_uart_tx #(
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_waddr_i,
  input  logic [31:0] mem_wdata_i,
  input  logic [31:0] mem_raddr_i,
  output logic [31:0] mem_rdata_o,
  output logic        tx_o,
  output logic        tx_idle_o
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned DIV_W = 16;
  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_BAUD   = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e             state_q, state_d;
  logic [7:0]         data_q, data_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [DIV_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         bit_q, bit_d;
  logic               tx_q, tx_d;
  logic               idle_q, idle_d;
  logic               ovf_q, ovf_d;
  logic [DIV_W-1:0]   baud_q, baud_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [7:0]         fifo_mem [FIFO_DEPTH];

  logic wr_hit, rd_hit, push_req, push, pop, full, empty, busy;
  logic unused_bits;

  assign unused_bits = ^{mem_waddr_i[1:0], mem_raddr_i[1:0], mem_wdata_i[31:16]};

  // Address decode and FIFO status, all from pre-edge state
  assign wr_hit   = mem_req_i & mem_we_i & (mem_waddr_i[31:4] == BASE_ADDR[31:4]);
  assign rd_hit   = mem_req_i & ~mem_we_i & (mem_raddr_i[31:4] == BASE_ADDR[31:4]);
  assign push_req = wr_hit & (mem_waddr_i[3:2] == REG_TXDATA);
  assign full     = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty    = (count_q == '0);
  assign push     = push_req & ~full;
  assign busy     = (state_q != S_IDLE);

  // Combinational read port
  always_comb begin
    mem_rdata_o = '0;
    if (rd_hit) begin
      case (mem_raddr_i[3:2])
        REG_STATUS: mem_rdata_o = {16'h0000, 8'(count_q), 4'h0, ovf_q, busy, empty, full};
        REG_BAUD:   mem_rdata_o = {16'h0000, baud_q};
        default:    mem_rdata_o = '0;
      endcase
    end
  end

  // Serialiser next-state; a frame starts by popping the FIFO and latching the divisor
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          data_d  = fifo_mem[rd_ptr_q];
          div_d   = baud_q;
          cnt_d   = baud_q - DIV_W'(1);
          tx_d    = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (cnt_q == '0) begin
          state_d = S_DATA;
          tx_d    = data_q[0];
          cnt_d   = div_q - DIV_W'(1);
          bit_d   = 3'd0;
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == '0) begin
          cnt_d = div_q - DIV_W'(1);
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
            tx_d    = ^data_q;
`else
            state_d = S_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = data_q[bit_q + 3'd1];
          end
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
      S_PARITY: begin
        if (cnt_q == '0) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
          cnt_d   = div_q - DIV_W'(1);
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
      S_STOP: begin
        if (cnt_q == '0) begin
          if (!empty) begin
            pop     = 1'b1;
            data_d  = fifo_mem[rd_ptr_q];
            div_d   = baud_q;
            cnt_d   = baud_q - DIV_W'(1);
            tx_d    = 1'b0;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // FIFO pointers, sticky overflow, divisor register and idle flag
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    ovf_d    = ovf_q;
    baud_d   = baud_q;
    if (wr_hit && (mem_waddr_i[3:2] == REG_STATUS) && mem_wdata_i[3]) begin
      ovf_d = 1'b0;
    end
    if (push_req && full) begin
      ovf_d = 1'b1;
    end
    if (wr_hit && (mem_waddr_i[3:2] == REG_BAUD)) begin
      baud_d = (mem_wdata_i[15:0] == 16'd0) ? DIV_W'(1) : mem_wdata_i[15:0];
    end
    idle_d = (count_d == '0) && (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      data_q   <= '0;
      div_q    <= DEFAULT_DIV;
      cnt_q    <= '0;
      bit_q    <= '0;
      tx_q     <= 1'b1;
      idle_q   <= 1'b1;
      ovf_q    <= 1'b0;
      baud_q   <= DEFAULT_DIV;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      div_q    <= div_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      tx_q     <= tx_d;
      idle_q   <= idle_d;
      ovf_q    <= ovf_d;
      baud_q   <= baud_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // FIFO storage needs no reset; pointers define validity
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= mem_wdata_i[7:0];
    end
  end

  assign tx_o      = tx_q;
  assign tx_idle_o = idle_q;

endmodule
